// File: rtl/program_loader.sv
// Byte-stream program loader: parses TGT/CNT/ADDR segments into word writes on the memory
// preload ports, then releases the core on GO. Define PROGRAM_LOADER_CHECKSUM_EN for per-segment XOR check.

`ifndef INSTR_MEM_ADDR_WIDTH
`define INSTR_MEM_ADDR_WIDTH 16
`endif
`ifndef INSTR_MEM_DATA_WIDTH
`define INSTR_MEM_DATA_WIDTH 32
`endif

module program_loader #(
    parameter int ADDR_WIDTH = `INSTR_MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = `INSTR_MEM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  preload_en_instr,
    output logic                  preload_en_data,
    output logic [ADDR_WIDTH-1:0] preload_addr,
    output logic [DATA_WIDTH-1:0] preload_data,
    output logic                  core_rst_n,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [3:0] {
        S_TGT,
        S_CNT0,
        S_CNT1,
        S_ADR0,
        S_ADR1,
        S_PAY,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] TGT_INSTR = 8'h49;
    localparam logic [7:0] TGT_DATA  = 8'h44;
    localparam logic [7:0] TGT_GO    = 8'h47;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t SEG_END = S_CSUM;
`else
    localparam state_t SEG_END = S_TGT;
`endif

    state_t                  state;
    logic                    sel_data;
    logic [15:0]             word_rem;
    logic [1:0]              byte_idx;
    logic [7:0]              adr_lo;
    logic [23:0]             word_buf;
    logic [ADDR_WIDTH-1:0]   addr_cur;
    logic                    acc;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]              csum;
`endif

    function automatic logic [ADDR_WIDTH-1:0] fit_addr(input logic [15:0] a);
        return ADDR_WIDTH'(a);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fit_word(input logic [31:0] w);
        return DATA_WIDTH'(w);
    endfunction

    assign acc = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_TGT;
            sel_data         <= 1'b0;
            word_rem         <= '0;
            byte_idx         <= '0;
            addr_cur         <= '0;
            in_ready         <= 1'b0;
            preload_en_instr <= 1'b0;
            preload_en_data  <= 1'b0;
            preload_addr     <= '0;
            preload_data     <= '0;
            core_rst_n       <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum             <= '0;
`endif
        end else begin
            preload_en_instr <= 1'b0;
            preload_en_data  <= 1'b0;
            in_ready         <= (state != S_DONE) && (state != S_ERR);
            if (acc) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (state != S_TGT && state != S_CSUM) csum <= csum ^ in_data;
`endif
                case (state)
                    S_TGT: begin
                        byte_idx <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                        case (in_data)
                            TGT_INSTR: begin
                                sel_data <= 1'b0;
                                state    <= S_CNT0;
                            end
                            TGT_DATA: begin
                                sel_data <= 1'b1;
                                state    <= S_CNT0;
                            end
                            TGT_GO: begin
                                state      <= S_DONE;
                                in_ready   <= 1'b0;
                                done       <= 1'b1;
                                core_rst_n <= 1'b1;
                            end
                            default: begin
                                state    <= S_ERR;
                                in_ready <= 1'b0;
                                error    <= 1'b1;
                            end
                        endcase
                    end
                    S_CNT0: begin
                        word_rem[7:0] <= in_data;
                        state         <= S_CNT1;
                    end
                    S_CNT1: begin
                        word_rem[15:8] <= in_data;
                        state          <= S_ADR0;
                    end
                    S_ADR0: begin
                        adr_lo <= in_data;
                        state  <= S_ADR1;
                    end
                    S_ADR1: begin
                        addr_cur <= fit_addr({in_data, adr_lo});
                        byte_idx <= '0;
                        state    <= (word_rem == 16'd0) ? SEG_END : S_PAY;
                    end
                    S_PAY: begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= in_data;
                            2'd1: word_buf[15:8]  <= in_data;
                            2'd2: word_buf[23:16] <= in_data;
                            default: begin
                                // Fourth byte completes the word: issue the write straight from the input.
                                if (sel_data) preload_en_data  <= 1'b1;
                                else          preload_en_instr <= 1'b1;
                                preload_addr <= addr_cur;
                                preload_data <= fit_word({in_data, word_buf});
                                addr_cur     <= addr_cur + ADDR_WIDTH'(4);
                                word_rem     <= word_rem - 16'd1;
                                if (word_rem == 16'd1) state <= SEG_END;
                            end
                        endcase
                    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (in_data == csum) begin
                            state <= S_TGT;
                        end else begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: image loads, address wrap, bad target, empty segment,
// mid-segment reset and (with PROGRAM_LOADER_CHECKSUM_EN) checksum accept/reject.

module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        preload_en_instr;
    logic        preload_en_data;
    logic [15:0] preload_addr;
    logic [31:0] preload_data;
    logic        core_rst_n;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    int          n_strobe = 0;
    int          both_seen = 0;
    logic [15:0] s_addr [0:15];
    logic [31:0] s_data [0:15];
    logic        s_isdata [0:15];
    logic [7:0]  run_x;
    int          base;

    always #5 clk = ~clk;

    program_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .preload_en_instr(preload_en_instr), .preload_en_data(preload_en_data),
        .preload_addr(preload_addr), .preload_data(preload_data),
        .core_rst_n(core_rst_n), .done(done), .error(error)
    );

    always @(negedge clk) begin
        if (preload_en_instr && preload_en_data) both_seen++;
        if (preload_en_instr || preload_en_data) begin
            if (n_strobe < 16) begin
                s_addr[n_strobe]   = preload_addr;
                s_data[n_strobe]   = preload_data;
                s_isdata[n_strobe] = preload_en_data;
            end
            n_strobe++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready) begin
            @(posedge clk);
        end else begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout byte=0x%0h in_ready=%0b required=1", b, in_ready);
        end
    endtask

    task automatic send_pb(input logic [7:0] b);
        send_byte(b);
        run_x = run_x ^ b;
    endtask

    task automatic seg_hdr(input logic [7:0] tgt, input logic [15:0] cnt, input logic [15:0] adr);
        send_byte(tgt);
        run_x = 8'h00;
        send_pb(cnt[7:0]);
        send_pb(cnt[15:8]);
        send_pb(adr[7:0]);
        send_pb(adr[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_pb(w[7:0]);
        send_pb(w[15:8]);
        send_pb(w[23:16]);
        send_pb(w[31:24]);
    endtask

    task automatic seg_end();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(run_x);
`endif
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        run_x    = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_en_instr", {31'd0, preload_en_instr}, 32'd0);
        check("rst_en_data", {31'd0, preload_en_data}, 32'd0);
        check("rst_addr", {16'd0, preload_addr}, 32'd0);
        check("rst_data", preload_data, 32'd0);
        check("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_release_in_ready", {31'd0, in_ready}, 32'd1);

        // Single instruction word with a mid-payload stall, then GO.
        base = n_strobe;
        seg_hdr(8'h49, 16'd1, 16'h0010);
        send_pb(8'h78);
        send_pb(8'h56);
        idle(3);
        check("stall_no_strobe", n_strobe - base, 32'd0);
        send_pb(8'h34);
        send_pb(8'h12);
        seg_end();
        send_byte(8'h47);
        idle(3);
        check("img1_strobes", n_strobe - base, 32'd1);
        check("img1_is_instr", {31'd0, s_isdata[base]}, 32'd0);
        check("img1_addr", {16'd0, s_addr[base]}, 32'h10);
        check("img1_data", s_data[base], 32'h12345678);
        check("img1_hold_addr", {16'd0, preload_addr}, 32'h10);
        check("img1_hold_data", preload_data, 32'h12345678);
        check("img1_done", {31'd0, done}, 32'd1);
        check("img1_core_rst_n", {31'd0, core_rst_n}, 32'd1);
        check("img1_in_ready", {31'd0, in_ready}, 32'd0);
        check("img1_error", {31'd0, error}, 32'd0);

        // Two data words crossing the top of the 16-bit address space.
        do_reset();
        base = n_strobe;
        seg_hdr(8'h44, 16'd2, 16'hFFFC);
        send_word(32'h44332211);
        send_word(32'h88776655);
        seg_end();
        send_byte(8'h47);
        idle(3);
        check("wrap_strobes", n_strobe - base, 32'd2);
        check("wrap_is_data0", {31'd0, s_isdata[base]}, 32'd1);
        check("wrap_addr0", {16'd0, s_addr[base]}, 32'hFFFC);
        check("wrap_data0", s_data[base], 32'h44332211);
        check("wrap_is_data1", {31'd0, s_isdata[base+1]}, 32'd1);
        check("wrap_addr1", {16'd0, s_addr[base+1]}, 32'h0000);
        check("wrap_data1", s_data[base+1], 32'h88776655);
        check("wrap_error", {31'd0, error}, 32'd0);
        check("wrap_done", {31'd0, done}, 32'd1);

        // Unknown target byte.
        do_reset();
        base = n_strobe;
        send_byte(8'h55);
        idle(1);
        check("badtgt_error", {31'd0, error}, 32'd1);
        check("badtgt_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        check("badtgt_in_ready", {31'd0, in_ready}, 32'd0);
        check("badtgt_done", {31'd0, done}, 32'd0);
        idle(3);
        check("badtgt_error_sticky", {31'd0, error}, 32'd1);
        check("badtgt_strobes", n_strobe - base, 32'd0);

        // Empty segment then GO.
        do_reset();
        check("rst_clears_error", {31'd0, error}, 32'd0);
        base = n_strobe;
        seg_hdr(8'h49, 16'd0, 16'h0020);
        seg_end();
        send_byte(8'h47);
        idle(2);
        check("empty_strobes", n_strobe - base, 32'd0);
        check("empty_done", {31'd0, done}, 32'd1);

        // Reset mid-word, then a fresh data image.
        do_reset();
        base = n_strobe;
        seg_hdr(8'h49, 16'd1, 16'h0040);
        send_pb(8'hAA);
        send_pb(8'hBB);
        do_reset();
        #1;
        check("partial_no_strobe", n_strobe - base, 32'd0);
        check("partial_done", {31'd0, done}, 32'd0);
        seg_hdr(8'h44, 16'd1, 16'h0008);
        send_word(32'hDEADBEEF);
        seg_end();
        send_byte(8'h47);
        idle(3);
        check("reload_strobes", n_strobe - base, 32'd1);
        check("reload_is_data", {31'd0, s_isdata[base]}, 32'd1);
        check("reload_addr", {16'd0, s_addr[base]}, 32'h0008);
        check("reload_data", s_data[base], 32'hDEADBEEF);
        check("reload_done", {31'd0, done}, 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // XOR of 01 00 00 00 01 00 00 00 is 00: 01 must be rejected, 00 accepted.
        do_reset();
        seg_hdr(8'h49, 16'd1, 16'h0000);
        send_word(32'h00000001);
        send_byte(8'h01);
        idle(1);
        check("csum_bad_error", {31'd0, error}, 32'd1);
        check("csum_bad_in_ready", {31'd0, in_ready}, 32'd0);
        do_reset();
        base = n_strobe;
        seg_hdr(8'h49, 16'd1, 16'h0000);
        send_word(32'h00000001);
        send_byte(8'h00);
        idle(1);
        check("csum_ok_error", {31'd0, error}, 32'd0);
        check("csum_ok_in_ready", {31'd0, in_ready}, 32'd1);
        send_byte(8'h47);
        idle(2);
        check("csum_ok_done", {31'd0, done}, 32'd1);
        check("csum_ok_strobes", n_strobe - base, 32'd1);
        check("csum_ok_data", s_data[base], 32'h00000001);
`endif

        check("no_dual_strobe", both_seen, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
